spike_window_monitor: RTL and testbench
=======================================

SPIKE_WINDOW_MONITOR -- requirements
Module: spike_window_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the count, interval and window fields.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port spike_in, input, 1: neuron spike, bit 0 of the neuron spike output, sampled every clk.
REQ-005 SHALL have port en, input, 1: monitoring enable.
REQ-006 SHALL have port win_len, input, CNT_W: window length in cycles; 0 means 2^CNT_W.
REQ-007 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-008 SHALL have port res_valid, output, 1: result registers valid.
REQ-009 SHALL have port spike_count, output, CNT_W: spikes in the window, saturating.
REQ-010 SHALL have port isi_min, output, CNT_W: minimum inter-spike interval in the window; all-ones means fewer than 2 spikes.
REQ-011 SHALL have port isi_last, output, CNT_W: the last inter-spike interval in the window; all-ones means fewer than 2 spikes.
REQ-012 SHALL have port ovf, output, 1: spike_count saturated in the window.
REQ-013 SHALL have port busy, output, 1: high while in COUNT.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, COUNT, HOLD.
REQ-015 IDLE: when en=1 at a clock edge, SHALL latch win_len and enter COUNT; the first sample is taken in the first COUNT cycle.
REQ-016 COUNT SHALL last exactly N cycles, where N = latched win_len (or 2^CNT_W when 0), and SHALL sample spike_in once per cycle.
REQ-017 Later changes to win_len SHALL NOT affect a window already in progress.
REQ-018 Each sampled spike SHALL increment the count, saturating at 2^CNT_W-1.
REQ-019 A spike that would exceed saturation SHALL set the ovf flag for that window.
REQ-020 Interval counter: SHALL be cleared on a sampled spike, incremented otherwise, and saturate at all-ones.
REQ-021 Interval value: the interval between spikes at samples i and j SHALL be j-i.
REQ-022 Interval update: on the second and later spikes, SHALL update isi_last and isi_min = min(isi_min, interval).
REQ-023 Interval history SHALL NOT carry across windows; the first spike of a window records no interval.
REQ-024 After the Nth sample, SHALL enter HOLD with the results registered and res_valid=1 on the next cycle (result latency: 1 cycle after the last sample).
REQ-025 Outputs SHALL be stable in HOLD until the handshake (res_valid & res_ready at a clock edge).
REQ-026 On the handshake with en=1: SHALL re-latch win_len and enter COUNT directly (back-to-back windows, no IDLE cycle).
REQ-027 On the handshake with en=0: SHALL enter IDLE and drop res_valid.
REQ-028 spike_in in IDLE and HOLD SHALL be ignored (not counted, no interval effect).
REQ-029 en=0 during COUNT SHALL abort the window: next state IDLE, no res_valid, previous result outputs unchanged.
REQ-030 en changes in HOLD SHALL NOT drop res_valid; en is evaluated only at the handshake.
REQ-031 res_valid SHALL never be asserted outside HOLD.
REQ-032 busy SHALL equal (state==COUNT).
REQ-033 spike_count, isi_min, isi_last and ovf SHALL retain the last delivered window's values in IDLE and COUNT; they update only on COUNT->HOLD.
REQ-034 Internal accumulators SHALL be cleared on every entry to COUNT.

Reset
REQ-035 rst_n=1 SHALL immediately (asynchronously) force state=IDLE and clear res_valid, busy and ovf.
REQ-036 rst_n=1 SHALL immediately clear spike_count=0 and set isi_min and isi_last to all-ones.
REQ-037 Reset mid-COUNT or in HOLD SHALL discard the window, with no result delivered.
REQ-038 After rst_n returns to 0, the first window SHALL start only after en is sampled high in IDLE.

Verification
REQ-039 Scenario: win_len=8, en=1, spike_in high at samples 1,4,5 -> res_valid 1 cycle after the 8th sample; spike_count=3, isi_last=1, isi_min=1, ovf=0.
REQ-040 Scenario: win_len=0, spike_in held 1 for all samples -> window lasts 256 cycles; spike_count=255, ovf=1, isi_min=1, isi_last=1.
REQ-041 Scenario: win_len=4, a single spike at sample 2, res_ready=0 for 5 cycles then 1 with en=1 -> spike_count=1, isi_min=isi_last=0xFF, stable across the stall; the next window starts the cycle after the handshake.
REQ-042 Scenario: win_len=10, en dropped at sample 5 -> busy falls, no res_valid, prior results unchanged, spikes afterward ignored.
REQ-043 Scenario: rst_n pulsed mid-HOLD between clock edges -> res_valid and outputs clear immediately; the next window requires en.
REQ-044 Scenario: win_len changed from 6 to 3 during a window -> the current window stays 6 samples; the next back-to-back window is 3 samples.

Source files
------------

// File: rtl/spike_window_monitor.sv
// Windowed spike statistics for one neuron: counts spikes over a latched
// window and reports spike count, min/last inter-spike interval and overflow.
module spike_window_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic             en,
  input  logic [CNT_W-1:0] win_len,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] spike_count,
  output logic [CNT_W-1:0] isi_min,
  output logic [CNT_W-1:0] isi_last,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t state, state_nxt;

  logic             start_win;
  logic             sample;
  logic             last_sample;

  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] samp_idx;

  logic [CNT_W-1:0] acc_count, acc_count_nxt;
  logic             acc_ovf, acc_ovf_nxt;
  logic [CNT_W-1:0] acc_isi_min, acc_isi_min_nxt;
  logic [CNT_W-1:0] acc_isi_last, acc_isi_last_nxt;
  logic [CNT_W-1:0] isi_cnt, isi_cnt_nxt;
  logic             acc_seen, acc_seen_nxt;
  logic [CNT_W-1:0] interval;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving COUNT on a dropped enable takes priority over finishing the window.
  always_comb begin
    state_nxt   = state;
    start_win   = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = COUNT;
          start_win = 1'b1;
        end
      end
      COUNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          sample = 1'b1;
          if (samp_idx == last_idx) begin
            last_sample = 1'b1;
            state_nxt   = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (en) begin
            state_nxt = COUNT;
            start_win = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_valid = (state == HOLD);
  assign busy      = (state == COUNT);

  // The interval counter holds (samples since last spike - 1), so the
  // interval seen at a new spike is one more than its current value.
  always_comb begin
    interval         = (isi_cnt == MAX) ? MAX : isi_cnt + ONE;
    acc_count_nxt    = acc_count;
    acc_ovf_nxt      = acc_ovf;
    acc_isi_min_nxt  = acc_isi_min;
    acc_isi_last_nxt = acc_isi_last;
    acc_seen_nxt     = acc_seen;
    isi_cnt_nxt      = (isi_cnt == MAX) ? MAX : isi_cnt + ONE;
    if (spike_in) begin
      isi_cnt_nxt  = '0;
      acc_seen_nxt = 1'b1;
      if (acc_count == MAX) begin
        acc_ovf_nxt = 1'b1;
      end else begin
        acc_count_nxt = acc_count + ONE;
      end
      if (acc_seen) begin
        acc_isi_last_nxt = interval;
        if (interval < acc_isi_min) begin
          acc_isi_min_nxt = interval;
        end
      end
    end
  end

  // Window length is stored as the index of the final sample; 0 wraps to MAX,
  // which gives the full 2^CNT_W window for free.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_idx     <= '0;
      samp_idx     <= '0;
      acc_count    <= '0;
      acc_ovf      <= 1'b0;
      acc_isi_min  <= MAX;
      acc_isi_last <= MAX;
      isi_cnt      <= '0;
      acc_seen     <= 1'b0;
    end else if (start_win) begin
      last_idx     <= win_len - ONE;
      samp_idx     <= '0;
      acc_count    <= '0;
      acc_ovf      <= 1'b0;
      acc_isi_min  <= MAX;
      acc_isi_last <= MAX;
      isi_cnt      <= '0;
      acc_seen     <= 1'b0;
    end else if (sample) begin
      samp_idx     <= samp_idx + ONE;
      acc_count    <= acc_count_nxt;
      acc_ovf      <= acc_ovf_nxt;
      acc_isi_min  <= acc_isi_min_nxt;
      acc_isi_last <= acc_isi_last_nxt;
      isi_cnt      <= isi_cnt_nxt;
      acc_seen     <= acc_seen_nxt;
    end
  end

  // Result registers only move when a full window completes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      spike_count <= '0;
      isi_min     <= MAX;
      isi_last    <= MAX;
      ovf         <= 1'b0;
    end else if (last_sample) begin
      spike_count <= acc_count_nxt;
      isi_min     <= acc_isi_min_nxt;
      isi_last    <= acc_isi_last_nxt;
      ovf         <= acc_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_spike_window_monitor.sv
// Self-checking bench for spike_window_monitor: table of windows with
// hand-computed results, scoreboard queue, plus abort/stall/reset sequences.
module tb_spike_window_monitor;

  logic       clk;
  logic       rst_n;
  logic       spike_in;
  logic       en;
  logic [7:0] win_len;
  logic       res_ready;
  logic       res_valid;
  logic [7:0] spike_count;
  logic [7:0] isi_min;
  logic [7:0] isi_last;
  logic       ovf;
  logic       busy;

  typedef struct {
    logic [7:0]   win_len;
    logic [255:0] mask;
    logic [7:0]   exp_count;
    logic [7:0]   exp_min;
    logic [7:0]   exp_last;
    logic         exp_ovf;
  } window_vec_t;

  window_vec_t vecs[9];
  window_vec_t exp_q[$];
  window_vec_t last_exp;

  int total = 0;
  int bad   = 0;

  spike_window_monitor #(.CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spike_in(spike_in),
    .en(en),
    .win_len(win_len),
    .res_ready(res_ready),
    .res_valid(res_valid),
    .spike_count(spike_count),
    .isi_min(isi_min),
    .isi_last(isi_last),
    .ovf(ovf),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkVals(input string tag, input logic [7:0] c, input logic [7:0] mn,
                           input logic [7:0] ls, input logic o);
    checkVal({tag, "_count"}, spike_count, c);
    checkVal({tag, "_isi_min"}, isi_min, mn);
    checkVal({tag, "_isi_last"}, isi_last, ls);
    checkVal({tag, "_ovf"}, ovf, o);
  endtask

  // Pops the oldest expected window result and compares it to the outputs.
  task automatic checkOutput();
    window_vec_t e;
    if (exp_q.size() == 0) begin
      checkVal("scoreboard_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      checkVals("result", e.exp_count, e.exp_min, e.exp_last, e.exp_ovf);
      last_exp = e;
    end
  endtask

  // Runs one full window; from_idle means en must still be raised in IDLE,
  // otherwise the window was already started by a back-to-back handshake.
  task automatic applyStimulus(input window_vec_t v, input bit from_idle);
    int n;
    n = (v.win_len == 8'd0) ? 256 : int'(v.win_len);
    if (from_idle) begin
      @(negedge clk);
      win_len   = v.win_len;
      en        = 1'b1;
      spike_in  = 1'b0;
      res_ready = 1'b0;
      @(posedge clk);
    end
    exp_q.push_back(v);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      checkVal("busy_in_count", busy, 1);
      checkVal("no_valid_in_count", res_valid, 0);
      res_ready = 1'b0;
      spike_in  = v.mask[s];
      if (s == 1) win_len = v.win_len + 8'd7;
    end
    @(negedge clk);
    spike_in = 1'b1;
    checkVal("res_valid_latency", res_valid, 1);
    checkVal("busy_in_hold", busy, 0);
    checkOutput();
  endtask

  task automatic handshake(input logic next_en, input logic [7:0] next_len);
    @(negedge clk);
    res_ready = 1'b1;
    en        = next_en;
    win_len   = next_len;
    spike_in  = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{8'd8,  256'h19,       8'd3,   8'd1,   8'd1,   1'b0};
    vecs[1] = '{8'd0,  {256{1'b1}},   8'd255, 8'd1,   8'd1,   1'b1};
    vecs[2] = '{8'd4,  256'h2,        8'd1,   8'hFF,  8'hFF,  1'b0};
    vecs[3] = '{8'd6,  256'h21,       8'd2,   8'd5,   8'd5,   1'b0};
    vecs[4] = '{8'd3,  256'h7,        8'd3,   8'd1,   8'd1,   1'b0};
    vecs[5] = '{8'd10, 256'h212,      8'd3,   8'd3,   8'd5,   1'b0};
    vecs[6] = '{8'd1,  256'h1,        8'd1,   8'hFF,  8'hFF,  1'b0};
    vecs[7] = '{8'd5,  256'h0,        8'd0,   8'hFF,  8'hFF,  1'b0};
    vecs[8] = '{8'd10, 256'h205,      8'd3,   8'd2,   8'd7,   1'b0};

    rst_n     = 1'b1;
    en        = 1'b0;
    spike_in  = 1'b0;
    win_len   = 8'd0;
    res_ready = 1'b0;
    #1;
    checkVals("reset", 8'd0, 8'hFF, 8'hFF, 1'b0);
    checkVal("reset_valid", res_valid, 0);
    checkVal("reset_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // Without en the monitor must stay idle, spikes or not.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      spike_in = 1'b1;
      checkVal("idle_busy", busy, 0);
      checkVal("idle_valid", res_valid, 0);
    end

    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        applyStimulus(vecs[i], 1'b1);
      end else begin
        handshake(1'b1, vecs[i].win_len);
        applyStimulus(vecs[i], 1'b0);
      end
      if (i == 2) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          res_ready = 1'b0;
          en        = c[0];
          spike_in  = 1'b1;
          checkVal("stall_valid", res_valid, 1);
          checkVals("stall", last_exp.exp_count, last_exp.exp_min, last_exp.exp_last, last_exp.exp_ovf);
        end
      end
    end

    handshake(1'b0, 8'd10);
    @(negedge clk);
    res_ready = 1'b0;
    checkVal("drop_valid", res_valid, 0);
    checkVal("drop_busy", busy, 0);
    checkVals("idle_retained", last_exp.exp_count, last_exp.exp_min, last_exp.exp_last, last_exp.exp_ovf);

    // Abort: en falls at sample 5 of a 10-sample window.
    @(negedge clk);
    en       = 1'b1;
    win_len  = 8'd10;
    spike_in = 1'b0;
    @(posedge clk);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkVal("abort_busy_before", busy, 1);
      checkVals("count_retained", last_exp.exp_count, last_exp.exp_min, last_exp.exp_last, last_exp.exp_ovf);
      spike_in = 1'b1;
      if (s == 4) en = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      spike_in = c[0];
      checkVal("abort_busy", busy, 0);
      checkVal("abort_valid", res_valid, 0);
    end
    checkVals("abort_retained", last_exp.exp_count, last_exp.exp_min, last_exp.exp_last, last_exp.exp_ovf);

    // Reset pulse in HOLD, between clock edges.
    applyStimulus(vecs[0], 1'b1);
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checkVal("hold_reset_valid", res_valid, 0);
    checkVal("hold_reset_busy", busy, 0);
    checkVals("hold_reset", 8'd0, 8'hFF, 8'hFF, 1'b0);
    #1 rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      spike_in = 1'b1;
      checkVal("post_reset_busy", busy, 0);
      checkVal("post_reset_valid", res_valid, 0);
    end

    // Reset mid-COUNT discards the window.
    @(negedge clk);
    en      = 1'b1;
    win_len = 8'd8;
    @(posedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    en = 1'b0;
    #1;
    checkVal("count_reset_busy", busy, 0);
    #1 rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkVal("count_reset_valid", res_valid, 0);
    end
    checkVals("count_reset", 8'd0, 8'hFF, 8'hFF, 1'b0);

    applyStimulus(vecs[5], 1'b1);
    handshake(1'b0, 8'd0);
    @(negedge clk);
    res_ready = 1'b0;
    checkVal("final_idle_valid", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
